// File: rtl/rv32i_mul_seq.sv
// Sequential shift-add multiplier for the EX stage (MUL / RSQR).
// Retires BITS_PER_CYCLE multiplier bits per cycle; low 32 bits only.
module rv32i_mul_seq #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_sqr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int N = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] N_LD = 6'(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] res_q;
  logic [31:0] part;
  logic [31:0] acc_nxt;
  logic [5:0]  cnt_q;
  logic        accept;
  logic        last;

  assign accept = start & ~flush;
  assign last   = (cnt_q == 6'd1);

  // mcand_q is pre-shifted each cycle, so bit k of
  // the multiplier always weighs mcand_q << k.
  always_comb begin
    part = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) begin
        part = part + (mcand_q << k);
      end
    end
  end

  assign acc_nxt = acc_q + part;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) state_d = RUN;
      end
      RUN: begin
        stall = ~flush;
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        mcand_q  <= rs1;
        mplier_q <= op_sqr ? rs1 : rs2;
        acc_q    <= '0;
        cnt_q    <= N_LD;
      end
    end else if (state_q == RUN && !flush) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      cnt_q    <= cnt_q - 6'd1;
      if (last) res_q <= acc_nxt;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: doc/rv32i_mul_seq.md
RV32I_MUL_SEQ -- requirements
Module: rv32i_mul_seq

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 2: multiplier bits retired per RUN cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: the EX stage holds a MUL or RSQR instruction.
REQ-005 SHALL have port op_sqr, input, 1 bit: 1 means RSQR (rs1*rs1); 0 means MUL (rs1*rs2).
REQ-006 SHALL have ports rs1 and rs2, inputs, 32 bits each: forwarded operands, already muxed with the immediate.
REQ-007 SHALL have port flush, input, 1 bit: the pipeline kills the instruction in EX.
REQ-008 SHALL have port stall, output, 1 bit: freezes IF/ID/EX while the multiply is in progress.
REQ-009 SHALL have port busy, output, 1 bit: the state is RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port result, output, 32 bits: the low 32 bits of the product.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE, with N = 32/BITS_PER_CYCLE RUN cycles.
REQ-013 SHALL take IDLE->RUN on a rising edge when start=1 and flush=0, latching the multiplicand (rs1) and the multiplier (op_sqr ? rs1 : rs2), clearing the accumulator and loading the counter with N.
REQ-014 SHALL, on each RUN edge, add the multiplicand shifted by the current bit position for each set bit among BITS_PER_CYCLE multiplier LSBs, shift the multiplier right, and decrement the counter, with the accumulator kept at 32 bits and carries above bit 31 discarded.
REQ-015 SHALL take RUN->DONE on the edge where the counter reaches 0, registering result from the accumulator on that same edge.
REQ-016 SHALL take DONE->IDLE unconditionally on the next edge.
REQ-017 SHALL ignore start in DONE, because it still reflects the retiring instruction.
REQ-018 SHALL have a fixed latency: done=1 exactly N+1 cycles after the accepting edge's cycle, i.e. the accepting edge plus N edges; there is no early-out on zero operands.
REQ-019 SHALL make result equal to the low 32 bits of rs1*rs2 for both signed and unsigned interpretations; no sign handling is needed.
REQ-020 SHALL drive stall combinationally as (IDLE and start and not flush) or RUN.
REQ-021 SHALL hold stall=0 in DONE, so the instruction leaves EX with result valid in that same cycle.
REQ-022 SHALL drive done = (state==DONE) and busy = (state==RUN).
REQ-023 SHALL hold result stable from DONE until the next DONE, and SHALL not change it on flush or on a new start.
REQ-024 SHALL, when flush=1 in RUN or DONE, go to IDLE on the next edge with no done pulse, and SHALL keep stall=0 combinationally while flush=1.
REQ-025 SHALL give flush priority over start when both are 1 in IDLE: the FSM stays in IDLE.
REQ-026 SHALL accept back-to-back operations: a start in the IDLE cycle right after DONE is accepted, so the minimum spacing is N+2 cycles.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, force state=IDLE, counter=0, accumulator=0, result=0, busy=0 and done=0.
REQ-028 SHALL let stall follow its REQ-020 equation from inputs during reset, since state=IDLE.
REQ-029 SHALL abandon a reset asserted mid-RUN with no done pulse; after release, result reads 0 until the next DONE.

Verification
REQ-030 SHALL cover: BITS_PER_CYCLE=2, rs1=7, rs2=6, start at cycle 0 -> stall=1 for cycles 0..16, done=1 only in cycle 17, result=42.
REQ-031 SHALL cover: op_sqr=1, rs1=0xFFFFFFFF, rs2=0x5 -> result=0x00000001 (rs2 ignored).
REQ-032 SHALL cover overflow wrap: 0x00010001*0x00010001 -> 0x00020001, and 0x80000000*2 -> 0x00000000.
REQ-033 SHALL cover: after a result of 42, flush in RUN cycle 5 -> IDLE next cycle, no done, stall=0, result stays 42.
REQ-034 SHALL cover: start held through DONE, a second op (3*5) presented in the next cycle -> exactly one done for the first op, then done N+1 cycles later with result=15.
REQ-035 SHALL cover: rst_n pulsed low mid-RUN -> busy, done and result drop to 0 without a clock edge, and no done follows.
